err_event_logger: RTL and testbench
===================================

# err_event_logger

Multi-channel error-event logger. It generalises the single-code error classifier to NUM_CH independent error sources. Each valid error code is classified (parity / timeout / overflow / unknown), counted per class, latched into sticky status, and queued into a round-robin-arbitrated log FIFO that software or a downstream block drains with a valid/ready handshake. It sits between the peripheral error sources and the system status/interrupt logic.

## Interface
- NUM_CH, 4: number of error source channels (1..8); CH_W = $clog2(NUM_CH), minimum 1
- CODE_W, 3: width of each raw error code
- CNT_W, 8: width of each per-class saturating counter and of drop_cnt
- DEPTH, 4: log FIFO depth (power of two, ≥2)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- err_valid  in  NUM_CH  per-channel error strobe, one event per high cycle
- err_code  in  NUM_CH*CODE_W  flattened codes; channel i at [i*CODE_W +: CODE_W]
- clr  in  1  synchronous clear of counters, sticky and drop_cnt
- log_ready  in  1  consumer accepts head entry
- log_valid  out  1  FIFO non-empty
- log_ch  out  CH_W  source channel of head entry
- log_class  out  2  class of head entry
- log_code  out  CODE_W  raw code of head entry
- cnt_bus  out  4*CNT_W  class counters; class k at [k*CNT_W +: CNT_W]
- sticky  out  4  bit k set once class k is seen
- drop_cnt  out  CNT_W  saturating count of overwritten (lost) events
- irq  out  1  registered, equals |sticky of the previous cycle

## Operation
- Classification: code 0 → PARITY (0); 3 → TIMEOUT (1); 5 → OVERFLOW (2); any other value → UNKNOWN (3). The decode has no priority; at most one class matches.
- Capture: when err_valid[i]=1, the code is written into channel i's 1-deep pending register on the next edge. cnt_bus[class] increments (saturating at 2^CNT_W−1) and sticky[class] sets, on the same edge.
- Overrun: if err_valid[i]=1 while pending[i] is occupied and not granted this cycle, the new event replaces the old one and drop_cnt increments (saturating). If pending[i] is granted in the same cycle, nothing is dropped.
- Arbitration: round-robin over occupied pending registers, starting at the channel after the last grant. One grant per cycle, and only when the FIFO is not full or is popped in the same cycle. A granted entry is pushed and its pending register freed on that edge.
- FIFO: pop occurs when log_valid && log_ready. Push and pop in the same cycle are legal at every fill level, including full; the count is then unchanged. When the FIFO is full with no pop, there is no grant and pending entries hold (backpressure).
- clr: zeroes cnt_bus, sticky and drop_cnt on the next edge. The FIFO and pending registers are untouched. If clr coincides with a capture, clr wins and that event is not counted.

## Timing
- Reset (rst_n=0 at edge): all pending registers empty; FIFO empty; log_valid=0; log_ch/log_class/log_code=0; cnt_bus=0; sticky=0; drop_cnt=0; irq=0; round-robin pointer set to channel 0 (highest priority first).
- Latency with an empty FIFO and no contention: err_valid at cycle N → pending at N+1 → granted, log_valid=1 at N+2.
- Counters and sticky are visible at N+1. irq follows at N+2.
- log_* outputs are driven from the FIFO head register. They are stable while log_valid && !log_ready.
- Reset asserted mid-operation discards all queued and pending events with no partial state.

## Configuration
- ERR_LOG_TS_EN defined: a free-running 16-bit timestamp counter (reset 0, wraps) is stamped into each pending entry at capture. The timestamp is carried through the FIFO and exposed on an extra output port log_ts (16 bits).
- ERR_LOG_TS_EN undefined: no timestamp counter, no log_ts port, and the FIFO is narrower. All other behaviour is identical.

## Structure
- Package err_log_pkg: enum err_class_e {CLS_PARITY, CLS_TIMEOUT, CLS_OVERFLOW, CLS_UNKNOWN}, code constants (CODE_PARITY=0, CODE_TIMEOUT=3, CODE_OVERFLOW=5), log entry struct typedef, and a classify function.
- Sub-module err_log_fifo: a parametrised synchronous FIFO (width, depth) with push/pop/full/empty.
- Arbitration, pending registers and counters stay in err_event_logger.

## Test plan
- Reset, then a single event ch0 code=5: cnt_bus[2]=1 and sticky=4'b0100 at N+1; log_valid=1, log_ch=0, log_class=2, log_code=5 at N+2; irq=1 at N+2.
- All four channels fire in one cycle with codes 0,3,5,7, log_ready=1: four pops in order ch0,ch1,ch2,ch3 with classes 0,1,2,3 on consecutive cycles; each counter=1; drop_cnt=0.
- log_ready=0, ch1 fires code 2 on DEPTH+2 consecutive cycles: FIFO fills with DEPTH entries, and drop_cnt counts every further event that finds pending[1] occupied and not granted; cnt_bus[3] equals the total number of events.
- 300 parity events with CNT_W=8: cnt_bus[0] saturates at 255. Then clr coincident with one more event: all counters and sticky read 0 next cycle.
- FIFO full with push and pop in the same cycle: the occupancy stays DEPTH, and the popped entry is the oldest.
- rst_n low mid-drain with 3 entries queued: log_valid=0 and all outputs 0 the next cycle; no stale entry after release.

Source files
------------

// File: rtl/err_log_pkg.sv
// Shared types and helpers for the multi-channel error-event logger.
// Build option: define ERR_LOG_TS_EN to carry a 16-bit capture timestamp
// with every logged event.
package err_log_pkg;

    typedef enum logic [1:0] {
        CLS_PARITY   = 2'd0,
        CLS_TIMEOUT  = 2'd1,
        CLS_OVERFLOW = 2'd2,
        CLS_UNKNOWN  = 2'd3
    } err_class_e;

    localparam int unsigned CODE_PARITY   = 0;
    localparam int unsigned CODE_TIMEOUT  = 3;
    localparam int unsigned CODE_OVERFLOW = 5;
    localparam int          NUM_CLS       = 4;

`ifdef ERR_LOG_TS_EN
    localparam int TS_W = 16;

    // Parameter-independent part of a log entry; channel and code are
    // appended by the logger because their widths are module parameters.
    typedef struct packed {
        logic [TS_W-1:0] ts;
        err_class_e      cls;
    } log_meta_t;
`else
    typedef struct packed {
        err_class_e cls;
    } log_meta_t;
`endif

    // Flat decode: the code constants are distinct, so at most one class matches.
    function automatic err_class_e classify(input logic [31:0] code);
        case (code)
            CODE_PARITY:   return CLS_PARITY;
            CODE_TIMEOUT:  return CLS_TIMEOUT;
            CODE_OVERFLOW: return CLS_OVERFLOW;
            default:       return CLS_UNKNOWN;
        endcase
    endfunction

endpackage

// File: rtl/err_log_fifo.sv
// Parametrised synchronous FIFO. Push and pop in the same cycle are accepted
// at any fill level, including full. dout reads zero while empty.
module err_log_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; count tracks validity and dout is masked while empty.
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/err_event_logger.sv
// Multi-channel error-event logger: classifies, counts and latches each error
// event, then round-robin arbitrates per-channel pending slots into a log FIFO.
// Build option: ERR_LOG_TS_EN adds a free-running timestamp and the log_ts port.
module err_event_logger
    import err_log_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CODE_W = 3,
    parameter  int CNT_W  = 8,
    parameter  int DEPTH  = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    err_valid,
    input  logic [NUM_CH*CODE_W-1:0] err_code,
    input  logic                 clr,
    input  logic                 log_ready,
    output logic                 log_valid,
    output logic [CH_W-1:0]      log_ch,
    output logic [1:0]           log_class,
    output logic [CODE_W-1:0]    log_code,
`ifdef ERR_LOG_TS_EN
    output logic [TS_W-1:0]      log_ts,
`endif
    output logic [4*CNT_W-1:0]   cnt_bus,
    output logic [3:0]           sticky,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic                 irq
);

    localparam int ENTRY_W = $bits(log_meta_t) + CH_W + CODE_W;

    logic [NUM_CH-1:0]  pend_vld;
    logic [CODE_W-1:0]  pend_code [NUM_CH];
`ifdef ERR_LOG_TS_EN
    logic [TS_W-1:0]    pend_ts [NUM_CH];
    logic [TS_W-1:0]    ts_cnt;
`endif
    logic [CH_W-1:0]    rr_ptr;
    logic [CH_W-1:0]    cand;
    logic               gnt_vld;
    logic [CH_W-1:0]    gnt_ch;
    logic               pop;
    logic               can_push;
    logic               fifo_full;
    logic               fifo_empty;
    log_meta_t          gnt_meta;
    log_meta_t          head_meta;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_data;
    logic [CNT_W-1:0]   cnt [NUM_CLS];
    logic [3:0]         cls_hits [NUM_CLS];
    logic [3:0]         drop_hits;
    err_class_e         cls_i;

    // Add a small per-cycle event count, clamping at the all-ones maximum.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
        logic [CNT_W+4:0] sum;
        sum = {5'd0, a} + {{(CNT_W+1){1'b0}}, b};
        return (sum > {5'd0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign log_valid = !fifo_empty;
    assign pop       = log_valid && log_ready;
    assign can_push  = !fifo_full || pop;

    // Round-robin pick of the first occupied pending slot at or after rr_ptr.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        cand    = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            cand = CH_W'((int'(rr_ptr) + off) % NUM_CH);
            if (!gnt_vld && pend_vld[cand]) begin
                gnt_vld = 1'b1;
                gnt_ch  = cand;
            end
        end
        if (!can_push) gnt_vld = 1'b0;
    end

    // Per-class event tally and overrun tally for this cycle's strobes.
    always_comb begin
        for (int k = 0; k < NUM_CLS; k++) cls_hits[k] = '0;
        drop_hits = '0;
        cls_i     = CLS_PARITY;
        for (int i = 0; i < NUM_CH; i++) begin
            if (err_valid[i]) begin
                cls_i           = classify(32'(err_code[i*CODE_W +: CODE_W]));
                cls_hits[cls_i] = cls_hits[cls_i] + 4'd1;
                if (pend_vld[i] && !(gnt_vld && gnt_ch == CH_W'(i)))
                    drop_hits = drop_hits + 4'd1;
            end
        end
    end

    // Assemble the granted entry: {meta, channel, code}.
    always_comb begin
        gnt_meta     = '0;
        gnt_meta.cls = classify(32'(pend_code[gnt_ch]));
`ifdef ERR_LOG_TS_EN
        gnt_meta.ts  = pend_ts[gnt_ch];
`endif
        push_data    = {gnt_meta, gnt_ch, pend_code[gnt_ch]};
    end

    // Control state: pending occupancy, arbitration pointer, counters, sticky, irq.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_vld <= '0;
            rr_ptr   <= '0;
            sticky   <= '0;
            drop_cnt <= '0;
            irq      <= 1'b0;
            for (int k = 0; k < NUM_CLS; k++) cnt[k] <= '0;
        end else begin
            if (gnt_vld)
                rr_ptr <= (gnt_ch == CH_W'(NUM_CH-1)) ? '0 : gnt_ch + 1'b1;
            // A new strobe re-occupies the slot even if it was granted this cycle.
            for (int i = 0; i < NUM_CH; i++) begin
                if (err_valid[i])
                    pend_vld[i] <= 1'b1;
                else if (gnt_vld && gnt_ch == CH_W'(i))
                    pend_vld[i] <= 1'b0;
            end
            irq <= |sticky;
            if (clr) begin
                sticky   <= '0;
                drop_cnt <= '0;
                for (int k = 0; k < NUM_CLS; k++) cnt[k] <= '0;
            end else begin
                drop_cnt <= sat_add(drop_cnt, drop_hits);
                for (int k = 0; k < NUM_CLS; k++) begin
                    cnt[k]    <= sat_add(cnt[k], cls_hits[k]);
                    sticky[k] <= sticky[k] | (cls_hits[k] != '0);
                end
            end
        end
    end

    // Pending payload capture; only meaningful while the matching pend_vld is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (err_valid[i]) begin
                pend_code[i] <= err_code[i*CODE_W +: CODE_W];
`ifdef ERR_LOG_TS_EN
                pend_ts[i]   <= ts_cnt;
`endif
            end
        end
    end

`ifdef ERR_LOG_TS_EN
    // Free-running capture timestamp, wraps at 2^16.
    always_ff @(posedge clk) begin
        if (!rst_n) ts_cnt <= '0;
        else        ts_cnt <= ts_cnt + 1'b1;
    end
`endif

    // Flatten the class counters onto the output bus.
    always_comb begin
        cnt_bus = '0;
        for (int k = 0; k < NUM_CLS; k++) cnt_bus[k*CNT_W +: CNT_W] = cnt[k];
    end

    err_log_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (gnt_vld),
        .din   (push_data),
        .pop   (pop),
        .dout  (head_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign log_code  = head_data[CODE_W-1:0];
    assign log_ch    = head_data[CODE_W +: CH_W];
    assign head_meta = head_data[ENTRY_W-1 -: $bits(log_meta_t)];
    assign log_class = head_meta.cls;
`ifdef ERR_LOG_TS_EN
    assign log_ts    = head_meta.ts;
`endif

endmodule

// File: tb/tb_err_event_logger.sv
// Self-checking bench for err_event_logger: a queue-based reference model runs
// on the clock, expected log entries go into a scoreboard queue, and a monitor
// on the falling edge compares every handshake and the status outputs.
module tb_err_event_logger;

    localparam int NUM_CH  = 4;
    localparam int CODE_W  = 3;
    localparam int CNT_W   = 8;
    localparam int DEPTH   = 4;
    localparam int CH_W    = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH-1:0]        err_valid;
    logic [NUM_CH*CODE_W-1:0] err_code;
    logic                     clr;
    logic                     log_ready;
    logic                     log_valid;
    logic [CH_W-1:0]          log_ch;
    logic [1:0]               log_class;
    logic [CODE_W-1:0]        log_code;
`ifdef ERR_LOG_TS_EN
    logic [15:0]              log_ts;
`endif
    logic [4*CNT_W-1:0]       cnt_bus;
    logic [3:0]               sticky;
    logic [CNT_W-1:0]         drop_cnt;
    logic                     irq;

    always #5 clk = ~clk;

    err_event_logger #(
        .NUM_CH (NUM_CH),
        .CODE_W (CODE_W),
        .CNT_W  (CNT_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .err_valid (err_valid),
        .err_code  (err_code),
        .clr       (clr),
        .log_ready (log_ready),
        .log_valid (log_valid),
        .log_ch    (log_ch),
        .log_class (log_class),
        .log_code  (log_code),
`ifdef ERR_LOG_TS_EN
        .log_ts    (log_ts),
`endif
        .cnt_bus   (cnt_bus),
        .sticky    (sticky),
        .drop_cnt  (drop_cnt),
        .irq       (irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int ch;
        int cls;
        int code;
        int ts;
    } ent_t;

    ent_t     m_fifo[$];
    ent_t     sb_q[$];
    bit       m_pv [NUM_CH];
    int       m_pc [NUM_CH];
    int       m_pts[NUM_CH];
    int       m_cnt[4];
    int       m_hits[4];
    int       m_ptr, m_drop, m_new_drops, m_ts, m_g;
    bit [3:0] m_sticky;
    bit       m_irq, m_pop;
    ent_t     m_e;

    function automatic int cls_of(input int code);
        if (code == 0) return 0;
        if (code == 3) return 1;
        if (code == 5) return 2;
        return 3;
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) m_pv[i] = 1'b0;
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
            m_ptr = 0; m_drop = 0; m_sticky = '0; m_irq = 1'b0; m_ts = 0;
            m_fifo.delete();
            sb_q.delete();
        end else begin
            m_pop = (m_fifo.size() != 0) && log_ready;
            m_g   = -1;
            if (m_fifo.size() < DEPTH || m_pop)
                for (int k = 0; k < NUM_CH; k++)
                    if (m_g < 0 && m_pv[(m_ptr + k) % NUM_CH]) m_g = (m_ptr + k) % NUM_CH;
            if (m_pop) void'(m_fifo.pop_front());
            if (m_g >= 0) begin
                m_e.ch   = m_g;
                m_e.code = m_pc[m_g];
                m_e.cls  = cls_of(m_pc[m_g]);
                m_e.ts   = m_pts[m_g];
                m_fifo.push_back(m_e);
                sb_q.push_back(m_e);
                m_pv[m_g] = 1'b0;
                m_ptr     = (m_g + 1) % NUM_CH;
            end
            m_irq = (m_sticky != 0);
            for (int k = 0; k < 4; k++) m_hits[k] = 0;
            m_new_drops = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (err_valid[i]) begin
                    if (m_pv[i]) m_new_drops++;
                    m_pv[i]  = 1'b1;
                    m_pc[i]  = int'(err_code[i*CODE_W +: CODE_W]);
                    m_pts[i] = m_ts;
                    m_hits[cls_of(m_pc[i])]++;
                end
            end
            if (clr) begin
                for (int k = 0; k < 4; k++) m_cnt[k] = 0;
                m_sticky = '0;
                m_drop   = 0;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    m_cnt[k] = sat(m_cnt[k] + m_hits[k]);
                    if (m_hits[k] != 0) m_sticky[k] = 1'b1;
                end
                m_drop = sat(m_drop + m_new_drops);
            end
            m_ts = (m_ts + 1) % 65536;
        end
    end

    // ---------------- monitor ----------------
    bit                 mon_en = 1'b0;
    int                 pop_ch[$];
    int                 pop_cls[$];
    int                 pop_code[$];
    logic [4*CNT_W-1:0] exp_bus;
    int                 mc;
    ent_t               mon_e;

    always @(negedge clk) begin
        if (mon_en) begin
            check("log_valid", log_valid, m_fifo.size() != 0);
            exp_bus = '0;
            for (int k = 0; k < 4; k++) begin
                mc = m_cnt[k];
                exp_bus[k*CNT_W +: CNT_W] = mc[CNT_W-1:0];
            end
            check("cnt_bus", cnt_bus, exp_bus);
            check("sticky", sticky, m_sticky);
            check("drop_cnt", drop_cnt, m_drop);
            check("irq", irq, m_irq);
            if (log_valid && log_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pop", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("log_ch", log_ch, mon_e.ch);
                    check("log_class", log_class, mon_e.cls);
                    check("log_code", log_code, mon_e.code);
`ifdef ERR_LOG_TS_EN
                    check("log_ts", log_ts, mon_e.ts);
`endif
                    pop_ch.push_back(int'(log_ch));
                    pop_cls.push_back(int'(log_class));
                    pop_code.push_back(int'(log_code));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [NUM_CH-1:0] v, input logic [NUM_CH*CODE_W-1:0] codes,
                         input logic rdy, input logic c);
        err_valid = v;
        err_code  = codes;
        log_ready = rdy;
        clr       = c;
        tick();
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) drive('0, '0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2, 1'b0);
        rst_n = 1'b1;
    endtask

    function automatic logic [NUM_CH*CODE_W-1:0] codes4(input int a, input int b, input int c, input int d);
        return {d[2:0], c[2:0], b[2:0], a[2:0]};
    endfunction

    task automatic clear_pops();
        pop_ch.delete();
        pop_cls.delete();
        pop_code.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        err_valid = '0;
        err_code  = '0;
        clr       = 1'b0;
        log_ready = 1'b0;
        idle(2, 1'b0);
        mon_en = 1'b1;

        // Reset state
        check("rst_log_valid", log_valid, 0);
        check("rst_log_ch", log_ch, 0);
        check("rst_log_class", log_class, 0);
        check("rst_log_code", log_code, 0);
        check("rst_cnt_bus", cnt_bus, 0);
        check("rst_sticky", sticky, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_irq", irq, 0);
        rst_n = 1'b1;

        // Single overflow event on ch0: counters at N+1, log entry and irq at N+2
        drive(4'b0001, codes4(5, 0, 0, 0), 1'b0, 1'b0);
        check("t1_cnt2", cnt_bus[2*CNT_W +: CNT_W], 1);
        check("t1_sticky", sticky, 4'b0100);
        check("t1_valid_n1", log_valid, 0);
        idle(1, 1'b0);
        check("t1_valid", log_valid, 1);
        check("t1_ch", log_ch, 0);
        check("t1_class", log_class, 2);
        check("t1_code", log_code, 5);
        check("t1_irq", irq, 1);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // All four channels at once, drained in channel order
        do_reset();
        clear_pops();
        drive(4'b1111, codes4(0, 3, 5, 7), 1'b1, 1'b0);
        idle(6, 1'b1);
        check("t2_npops", pop_ch.size(), 4);
        for (int i = 0; i < 4 && i < pop_ch.size(); i++) begin
            check("t2_order_ch", pop_ch[i], i);
            check("t2_order_cls", pop_cls[i], i);
        end
        check("t2_cnts", cnt_bus, 32'h01010101);
        check("t2_drop", drop_cnt, 0);

        // Backpressure on ch1: FIFO fills, one overrun
        do_reset();
        repeat (DEPTH + 2) drive(4'b0010, codes4(0, 2, 0, 0), 1'b0, 1'b0);
        idle(2, 1'b0);
        check("t3_drop", drop_cnt, 1);
        check("t3_cnt3", cnt_bus[3*CNT_W +: CNT_W], DEPTH + 2);
        check("t3_valid", log_valid, 1);
        idle(DEPTH + 4, 1'b1);

        // Counter saturation, then clr coincident with an event
        do_reset();
        repeat (300) drive(4'b0001, codes4(0, 0, 0, 0), 1'b1, 1'b0);
        check("t4_sat", cnt_bus[0 +: CNT_W], CNT_MAX);
        drive(4'b0001, codes4(0, 0, 0, 0), 1'b1, 1'b1);
        check("t4_clr_cnt", cnt_bus, 0);
        check("t4_clr_sticky", sticky, 0);
        check("t4_clr_drop", drop_cnt, 0);
        idle(4, 1'b1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        drive(4'b1111, codes4(1, 2, 4, 6), 1'b0, 1'b0);
        idle(5, 1'b0);
        drive(4'b0001, codes4(7, 0, 0, 0), 1'b0, 1'b0);
        idle(2, 1'b0);
        clear_pops();
        drive('0, '0, 1'b1, 1'b0);
        check("t5_still_valid", log_valid, 1);
        check("t5_pop1", pop_ch.size(), 1);
        if (pop_ch.size() >= 1) begin
            check("t5_oldest_ch", pop_ch[0], 0);
            check("t5_oldest_code", pop_code[0], 1);
        end
        idle(1, 1'b0);
        idle(DEPTH + 4, 1'b1);
        check("t5_total_pops", pop_ch.size(), DEPTH + 1);
        if (pop_ch.size() == DEPTH + 1) check("t5_last_code", pop_code[DEPTH], 7);

        // Reset while three entries are queued
        do_reset();
        drive(4'b0111, codes4(3, 5, 7, 0), 1'b0, 1'b0);
        idle(4, 1'b0);
        check("t6_queued", log_valid, 1);
        rst_n = 1'b0;
        drive('0, '0, 1'b1, 1'b0);
        check("t6_valid", log_valid, 0);
        check("t6_ch", log_ch, 0);
        check("t6_class", log_class, 0);
        check("t6_code", log_code, 0);
        check("t6_cnt", cnt_bus, 0);
        check("t6_sticky", sticky, 0);
        check("t6_irq", irq, 0);
        rst_n = 1'b1;
        idle(4, 1'b1);
        check("t6_no_stale", log_valid, 0);

        // Randomised traffic: light then heavy backpressure, rare clr
        do_reset();
        for (int n = 0; n < 600; n++) begin
            drive(NUM_CH'($urandom), (NUM_CH*CODE_W)'($urandom),
                  (n < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 49) == 0));
        end
        idle(12, 1'b1);
        check("rand_drained", log_valid, 0);
        check("rand_sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
